// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } loader_state_e;

    localparam int          IMEM_HDR_BYTES = 2;
    localparam logic [31:0] IMEM_OOR_DATA  = 32'h0;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - DEPTH x 32 instruction RAM, synchronous write, asynchronous read
module imem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];

    // No reset: contents survive reset and aborted loads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: receives a checksummed byte image into instruction RAM, then serves fetches
import imem_loader_pkg::*;

module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        reload,
    input  logic [31:0] i_mem_r_addr,
    output logic [31:0] i_mem_r_data,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err,
    output logic [15:0] word_count
);

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    loader_state_e state_q;
    logic [7:0]    n_lo_q;
    logic [15:0]   word_count_q;
    logic [AW:0]   wr_ptr_q;
    logic [1:0]    byte_idx_q;
    logic [7:0]    csum_q;
    logic [23:0]   asm_q;

    logic          accept;
    logic [15:0]   n_d;
    logic [AW:0]   wr_ptr_d;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          fetch_oor;
    logic          unused_addr_lsbs;

    assign rx_ready  = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept    = rx_valid && rx_ready;
    assign n_d       = {rx_data, n_lo_q};
    assign wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    assign ram_we    = accept && (state_q == S_DATA) && (byte_idx_q == 2'd3);
    assign ram_wdata = {rx_data, asm_q};

    assign core_rst   = (state_q != S_RUN);
    assign load_done  = (state_q == S_RUN);
    assign load_err   = (state_q == S_ERR);
    assign word_count = word_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HDR_LO;
            n_lo_q       <= 8'h00;
            word_count_q <= 16'h0000;
            wr_ptr_q     <= '0;
            byte_idx_q   <= 2'd0;
            csum_q       <= 8'h00;
            asm_q        <= 24'h0;
        end else begin
            case (state_q)
                S_HDR_LO: if (accept) begin
                    n_lo_q  <= rx_data;
                    state_q <= S_HDR_HI;
                end
                S_HDR_HI: if (accept) begin
                    word_count_q <= n_d;
                    if ({1'b0, n_d} > DEPTH_W) begin
                        state_q <= S_ERR;
                    end else if (n_d == 16'h0000) begin
                        state_q <= S_CSUM;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: if (accept) begin
                    // Little-endian assembly: earlier bytes shift toward bit 0.
                    asm_q      <= {rx_data, asm_q[23:8]};
                    csum_q     <= csum_q ^ rx_data;
                    byte_idx_q <= byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wr_ptr_q <= wr_ptr_d;
                        if (16'(wr_ptr_d) == word_count_q) begin
                            state_q <= S_CSUM;
                        end
                    end
                end
                S_CSUM: if (accept) begin
                    state_q <= (rx_data == csum_q) ? S_RUN : S_ERR;
                end
                S_RUN, S_ERR: if (reload) begin
                    state_q    <= S_HDR_LO;
                    wr_ptr_q   <= '0;
                    byte_idx_q <= 2'd0;
                    csum_q     <= 8'h00;
                end
                default: state_q <= S_HDR_LO;
            endcase
        end
    end

    imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (ram_wdata),
        .raddr (i_mem_r_addr[AW+1:2]),
        .rdata (ram_rdata)
    );

    // Fetches past the RAM return a fixed word rather than aliasing low addresses.
    assign fetch_oor        = |i_mem_r_addr[31:AW+2];
    assign i_mem_r_data     = fetch_oor ? IMEM_OOR_DATA : ram_rdata;
    assign unused_addr_lsbs = ^i_mem_r_addr[1:0];

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with image-level reference model
module tb_imem_loader;

    localparam int DEPTH  = 1024;
    localparam int HDR    = 2;
    localparam int ST_RUN = 1;
    localparam int ST_ERR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        reload;
    logic [31:0] i_mem_r_addr;
    logic [31:0] i_mem_r_data;
    logic        core_rst;
    logic        load_done;
    logic        load_err;
    logic [15:0] word_count;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_mem [DEPTH];
    bit          known   [DEPTH];
    logic [7:0]  img_q [$];

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .reload       (reload),
        .i_mem_r_addr (i_mem_r_addr),
        .i_mem_r_data (i_mem_r_data),
        .core_rst     (core_rst),
        .load_done    (load_done),
        .load_err     (load_err),
        .word_count   (word_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int budget = 50;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input int first, input int max_gap);
        for (int i = first; i < img_q.size(); i++) send_byte(img_q[i], max_gap);
    endtask

    // Reference: decode the whole image from the format rules and predict RAM + final state.
    task automatic model_image(output int exp_state, output int exp_n);
        logic [7:0] cs = 8'h00;
        int         n;
        n = int'({img_q[1], img_q[0]});
        exp_n = n;
        if (n > DEPTH) begin
            exp_state = ST_ERR;
            return;
        end
        for (int w = 0; w < n; w++) begin
            int base = HDR + 4 * w;
            exp_mem[w] = {img_q[base+3], img_q[base+2], img_q[base+1], img_q[base]};
            known[w]   = 1'b1;
            cs = cs ^ img_q[base] ^ img_q[base+1] ^ img_q[base+2] ^ img_q[base+3];
        end
        exp_state = (img_q[HDR + 4 * n] == cs) ? ST_RUN : ST_ERR;
    endtask

    task automatic make_image(input int n, input bit good);
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        img_q = {};
        img_q.push_back(n[7:0]);
        img_q.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            img_q.push_back(b);
        end
        if (!good) cs ^= 8'($urandom_range(255, 1));
        img_q.push_back(cs);
    endtask

    task automatic check_status(input string tag, input int exp_state, input int exp_n);
        check({tag, ".load_done"},  32'(load_done),  32'(exp_state == ST_RUN));
        check({tag, ".load_err"},   32'(load_err),   32'(exp_state == ST_ERR));
        check({tag, ".core_rst"},   32'(core_rst),   32'(exp_state != ST_RUN));
        check({tag, ".rx_ready"},   32'(rx_ready),   32'd0);
        check({tag, ".word_count"}, 32'(word_count), 32'(exp_n));
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        @(negedge clk);
        i_mem_r_addr = addr;
        #1;
        check(tag, i_mem_r_data, exp);
    endtask

    task automatic check_known();
        for (int w = 0; w < 16; w++)
            if (known[w]) check_fetch("fetch_known", 32'(w * 4 + $urandom_range(3, 0)), exp_mem[w]);
    endtask

    task automatic do_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("reload.core_rst", 32'(core_rst), 32'd1);
        check("reload.rx_ready", 32'(rx_ready), 32'd1);
    endtask

    initial begin
        int st;
        int n;

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; reload = 1'b0; i_mem_r_addr = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst.core_rst",   32'(core_rst),   32'd1);
        check("rst.load_done",  32'(load_done),  32'd0);
        check("rst.load_err",   32'(load_err),   32'd0);
        check("rst.rx_ready",   32'(rx_ready),   32'd1);
        check("rst.word_count", 32'(word_count), 32'd0);

        // Two-word good image; core released the cycle after the checksum byte.
        img_q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        send_image(0, 2);
        model_image(st, n);
        check_status("img2", st, n);
        check_fetch("fetch_0x0", 32'h0, 32'h44332211);
        check_fetch("fetch_0x4", 32'h4, 32'h88776655);
        check_fetch("fetch_0x6", 32'h6, 32'h88776655);

        // Bad checksum: words still written, core held in reset.
        do_reload();
        img_q = '{8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
        send_image(0, 1);
        model_image(st, n);
        check_status("badcsum", st, n);
        check_known();

        // Oversized header: error right after hi byte, RAM untouched.
        do_reload();
        img_q = '{8'h01, 8'h04};
        send_image(0, 1);
        model_image(st, n);
        check_status("oversize", st, n);
        check_known();

        // Empty image and out-of-range fetches.
        do_reload();
        img_q = '{8'h00, 8'h00, 8'h00};
        send_image(0, 1);
        model_image(st, n);
        check_status("empty", st, n);
        check_fetch("fetch_oor_1000", 32'h1000, 32'h0);
        check_fetch("fetch_oor_max",  32'hFFFF_FFFF, 32'h0);

        // Abort mid-load with reset, then load a fresh one-word image.
        do_reload();
        make_image(2, 1'b1);
        for (int i = 0; i < HDR + 5; i++) begin
            send_byte(img_q[i], 3);
            check("abort.core_rst", 32'(core_rst), 32'd1);
        end
        exp_mem[0] = {img_q[5], img_q[4], img_q[3], img_q[2]};
        known[0]   = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("abort.rst_wc",    32'(word_count), 32'd0);
        check("abort.rst_ready", 32'(rx_ready),   32'd1);
        make_image(1, 1'b1);
        send_image(0, 2);
        model_image(st, n);
        check_status("after_abort", st, n);
        check_known();

        // In S_RUN a held byte is ignored; reload then beats a simultaneous byte.
        rx_data = 8'hAA; rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("hold.load_done",  32'(load_done),  32'd1);
        check("hold.word_count", 32'(word_count), 32'(n));
        make_image(3, 1'b1);
        rx_data = img_q[0];
        reload  = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check("race.core_rst", 32'(core_rst), 32'd1);
        check("race.rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        check("race.lo_taken", 32'(word_count), 32'(n));
        send_image(1, 2);
        model_image(st, n);
        check_status("race_img", st, n);
        check_known();

        // Randomized images, a third with corrupted checksums.
        for (int k = 0; k < 6; k++) begin
            do_reload();
            make_image($urandom_range(6, 1), (k % 3) != 1);
            send_image(0, 3);
            model_image(st, n);
            check_status("rand", st, n);
            check_known();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
